// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencing controller.
//   - FSM state encoding
//   - lane_width(): width of the last_lanes operand for a given lane count
//   - job_latency(): accept-to-done cycle count for a job of n words
package softmax_pkg;

  localparam int unsigned STATE_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_MAX_RD    = 4'd1;
  localparam logic [3:0] S_MAX_DRAIN = 4'd2;
  localparam logic [3:0] S_SUM_RD    = 4'd3;
  localparam logic [3:0] S_SUM_DRAIN = 4'd4;
  localparam logic [3:0] S_LOG       = 4'd5;
  localparam logic [3:0] S_OUT_RD    = 4'd6;
  localparam logic [3:0] S_OUT_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  // Width needed to hold a lane count in 0..num.
  function automatic int unsigned lane_width(input int unsigned num);
    return $clog2(num + 1);
  endfunction

  // Cycle of the done pulse, counting the accepting edge as cycle 0.
  function automatic int unsigned job_latency(input int unsigned n,
                                              input int unsigned max_depth,
                                              input int unsigned sum_depth,
                                              input int unsigned exp_lat);
    return 3 * n + 5 + max_depth + sum_depth + 2 * exp_lat;
  endfunction

endpackage

// File: rtl/softmax_valid_pipe.sv
// Fixed-depth alignment shift register for {valid, lane mask, address}.
// Ports:
//   clk, rst_n        clock, asynchronous active-low clear
//   flush             synchronous clear of every stage (job abort)
//   in_valid/mask/addr  word entering the pipe
//   out_valid/mask/addr word leaving the pipe DEPTH cycles later
// Mask and address are forced to zero alongside a cleared valid, so
// downstream logic may OR masks from several pipes without gating.
module softmax_valid_pipe #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned MASK_W = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [MASK_W-1:0] in_mask,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [MASK_W-1:0] out_mask,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [MASK_W-1:0] msk_q [DEPTH];
  logic [MASK_W-1:0] msk_d [DEPTH];
  logic [ADDR_W-1:0] adr_q [DEPTH];
  logic [ADDR_W-1:0] adr_d [DEPTH];

  // Stage shift; invalid stages carry zero payload by construction.
  always_comb begin
    vld_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      msk_d[i] = '0;
      adr_d[i] = '0;
    end
    if (!flush) begin
      if (in_valid) begin
        vld_d[0] = 1'b1;
        msk_d[0] = in_mask;
        adr_d[0] = in_addr;
      end
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        msk_d[i] = msk_q[i-1];
        adr_d[i] = adr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        msk_q[i] <= '0;
        adr_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        msk_q[i] <= msk_d[i];
        adr_q[i] <= adr_d[i];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_mask  = msk_q[DEPTH-1];
  assign out_addr  = adr_q[DEPTH-1];

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencing controller: runs three read passes (max, sum, output)
// over the words start_addr..end_addr through one read port and produces the
// aligned strobes, lane masks and write addresses for the datapath.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   start, abort                job request (IDLE only), job cancel
//   start_addr, end_addr        inclusive word range of the vector
//   last_lanes                  valid lanes in the word at end_addr
//   busy, err, done             job status
//   rd_en, rd_addr              memory read port (1-cycle latency)
//   max_en, max_latch           max tree input valid / result final
//   sum_en, sum_latch           adder tree input valid / result final
//   log_en                      latch ln(sum)
//   out_valid, out_addr         final exp result valid and its address
//   lane_mask                   lanes valid for the active strobe
module softmax_seq_ctrl
  import softmax_pkg::*;
#(
  parameter  int unsigned NUM       = 4,
  parameter  int unsigned ADDRSIZE  = 8,
  parameter  int unsigned MAX_DEPTH = 2,
  parameter  int unsigned SUM_DEPTH = 2,
  parameter  int unsigned EXP_LAT   = 1,
  localparam int unsigned LW        = lane_width(NUM)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDRSIZE-1:0] start_addr,
  input  logic [ADDRSIZE-1:0] end_addr,
  input  logic [LW-1:0]       last_lanes,
  output logic                busy,
  output logic                err,
  output logic                done,
  output logic                rd_en,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic                max_en,
  output logic                max_latch,
  output logic                sum_en,
  output logic                sum_latch,
  output logic                log_en,
  output logic                out_valid,
  output logic [ADDRSIZE-1:0] out_addr,
  output logic [NUM-1:0]      lane_mask
);

  localparam int unsigned SUM_WAIT = EXP_LAT + SUM_DEPTH;
  localparam int unsigned CNT_MAX  = (MAX_DEPTH > SUM_WAIT) ? MAX_DEPTH : SUM_WAIT;
  localparam int unsigned CW       = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned EXP_D    = 1 + EXP_LAT;

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRSIZE-1:0] start_q, start_d;
  logic [ADDRSIZE-1:0] end_q, end_d;
  logic [LW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                max_latch_q, max_latch_d;
  logic                sum_latch_q, sum_latch_d;
  logic                log_en_q, log_en_d;

  logic                start_ok_c;
  logic                flush_c;
  logic [NUM-1:0]      rd_mask_c;
  logic                max_in_c, sum_in_c, out_in_c;
  logic [NUM-1:0]      max_mask, sum_mask, out_mask;
  logic [ADDRSIZE-1:0] max_addr_unused, sum_addr_unused;

  assign start_ok_c = (end_addr >= start_addr) && (last_lanes != '0) &&
                      (last_lanes <= LW'(NUM));

  // Next state, operand latch and address/drain counters.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    start_d   = start_q;
    end_d     = end_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    flush_c   = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      rd_addr_d = '0;
      cnt_d     = '0;
      flush_c   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok_c) begin
              state_d   = S_MAX_RD;
              rd_addr_d = start_addr;
              start_d   = start_addr;
              end_d     = end_addr;
              last_d    = last_lanes;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        // Stop on equality so a range ending at the top address never wraps.
        S_MAX_RD, S_SUM_RD, S_OUT_RD: begin
          if (rd_addr_q == end_q) begin
            rd_addr_d = '0;
            cnt_d     = '0;
            state_d   = (state_q == S_MAX_RD) ? S_MAX_DRAIN :
                        (state_q == S_SUM_RD) ? S_SUM_DRAIN : S_OUT_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + ADDRSIZE'(1);
          end
        end
        S_MAX_DRAIN: begin
          if (cnt_q == CW'(MAX_DEPTH)) begin
            state_d   = S_SUM_RD;
            rd_addr_d = start_q;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SUM_DRAIN: begin
          if (cnt_q == CW'(SUM_WAIT)) begin
            state_d = S_LOG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_LOG: begin
          state_d   = S_OUT_RD;
          rd_addr_d = start_q;
        end
        S_OUT_DRAIN: begin
          if (cnt_q == CW'(EXP_LAT)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs decoded from the next state so they are flopped with it.
    busy_d      = (state_d != S_IDLE);
    rd_en_d     = (state_d == S_MAX_RD) || (state_d == S_SUM_RD) ||
                  (state_d == S_OUT_RD);
    max_latch_d = (state_d == S_MAX_DRAIN) && (cnt_d == CW'(MAX_DEPTH));
    sum_latch_d = (state_d == S_SUM_DRAIN) && (cnt_d == CW'(SUM_WAIT));
    log_en_d    = (state_d == S_LOG);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      start_q     <= '0;
      end_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      max_latch_q <= 1'b0;
      sum_latch_q <= 1'b0;
      log_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      start_q     <= start_d;
      end_q       <= end_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
      max_latch_q <= max_latch_d;
      sum_latch_q <= sum_latch_d;
      log_en_q    <= log_en_d;
    end
  end

  // Mask of the word being read: the final word keeps only its low lanes.
  always_comb begin
    rd_mask_c = '1;
    if (rd_addr_q == end_q) begin
      for (int i = 0; i < NUM; i++) begin
        rd_mask_c[i] = (LW'(i) < last_q);
      end
    end
  end

  assign max_in_c = rd_en_q && (state_q == S_MAX_RD);
  assign sum_in_c = rd_en_q && (state_q == S_SUM_RD);
  assign out_in_c = rd_en_q && (state_q == S_OUT_RD);

  softmax_valid_pipe #(
    .DEPTH  (1),
    .MASK_W (NUM),
    .ADDR_W (ADDRSIZE)
  ) u_max_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush_c),
    .in_valid  (max_in_c),
    .in_mask   (rd_mask_c),
    .in_addr   (rd_addr_q),
    .out_valid (max_en),
    .out_mask  (max_mask),
    .out_addr  (max_addr_unused)
  );

  softmax_valid_pipe #(
    .DEPTH  (EXP_D),
    .MASK_W (NUM),
    .ADDR_W (ADDRSIZE)
  ) u_sum_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush_c),
    .in_valid  (sum_in_c),
    .in_mask   (rd_mask_c),
    .in_addr   (rd_addr_q),
    .out_valid (sum_en),
    .out_mask  (sum_mask),
    .out_addr  (sum_addr_unused)
  );

  softmax_valid_pipe #(
    .DEPTH  (EXP_D),
    .MASK_W (NUM),
    .ADDR_W (ADDRSIZE)
  ) u_out_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush_c),
    .in_valid  (out_in_c),
    .in_mask   (rd_mask_c),
    .in_addr   (rd_addr_q),
    .out_valid (out_valid),
    .out_mask  (out_mask),
    .out_addr  (out_addr)
  );

  // Passes never overlap and idle pipes hold zero masks, so this OR only
  // ever forwards one registered mask.
  assign lane_mask = max_mask | sum_mask | out_mask;

  assign busy      = busy_q;
  assign err       = err_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign max_latch = max_latch_q;
  assign sum_latch = sum_latch_q;
  assign log_en    = log_en_q;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl at default parameters.
// Cycle c is the interval starting at the c-th rising edge after the accept
// edge; all outputs are sampled 1 time unit after each rising edge.
module tb_softmax_seq_ctrl;
  import softmax_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] start_addr;
  logic [7:0] end_addr;
  logic [2:0] last_lanes;
  logic       busy, err, done, rd_en;
  logic [7:0] rd_addr;
  logic       max_en, max_latch, sum_en, sum_latch, log_en, out_valid;
  logic [7:0] out_addr;
  logic [3:0] lane_mask;

  int n_vec = 0;
  int n_err = 0;

  softmax_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .last_lanes (last_lanes),
    .busy       (busy),
    .err        (err),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .max_en     (max_en),
    .max_latch  (max_latch),
    .sum_en     (sum_en),
    .sum_latch  (sum_latch),
    .log_en     (log_en),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .lane_mask  (lane_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] pk(input logic b, input logic e, input logic d,
                                     input logic re, input logic [7:0] ra,
                                     input logic me, input logic ml,
                                     input logic se, input logic sl,
                                     input logic le, input logic ov,
                                     input logic [7:0] oa, input logic [3:0] lm);
    return {b, e, d, re, ra, me, ml, se, sl, le, ov, oa, lm};
  endfunction

  function automatic logic [29:0] obs();
    return pk(busy, err, done, rd_en, rd_addr, max_en, max_latch, sum_en,
              sum_latch, log_en, out_valid, out_addr, lane_mask);
  endfunction

  // Hand-derived schedule for MAX_DEPTH=2, SUM_DEPTH=2, EXP_LAT=1:
  //   reads 1..n, n+4..2n+3, 2n+9..3n+8; max_en 2..n+1; max_latch n+3;
  //   sum_en n+6..2n+5; sum_latch 2n+7; log_en 2n+8;
  //   out_valid 2n+11..3n+10; done 3n+11.
  function automatic logic [29:0] exp_at(input int c, input int n,
                                         input logic [7:0] sa, input logic [2:0] ll);
    logic b, d, re, me, ml, se, sl, le, ov;
    logic [7:0] ra, oa;
    logic [3:0] lm, full;
    int off;
    full = 4'hF;
    b  = (c >= 1) && (c <= 3 * n + 11);
    d  = (c == 3 * n + 11);
    re = 1'b0;
    ra = 8'h00;
    if (c >= 1 && c <= n) begin re = 1'b1; ra = sa + 8'(c - 1); end
    if (c >= n + 4 && c <= 2 * n + 3) begin re = 1'b1; ra = sa + 8'(c - n - 4); end
    if (c >= 2 * n + 9 && c <= 3 * n + 8) begin re = 1'b1; ra = sa + 8'(c - 2 * n - 9); end
    me = (c >= 2) && (c <= n + 1);
    se = (c >= n + 6) && (c <= 2 * n + 5);
    ov = (c >= 2 * n + 11) && (c <= 3 * n + 10);
    off = -1;
    if (me) off = c - 2;
    if (se) off = c - n - 6;
    if (ov) off = c - 2 * n - 11;
    oa = ov ? sa + 8'(off) : 8'h00;
    ml = (c == n + 3);
    sl = (c == 2 * n + 7);
    le = (c == 2 * n + 8);
    lm = 4'h0;
    if (off >= 0) lm = (off == n - 1) ? (full >> (4 - int'(ll))) : full;
    return pk(b, 1'b0, d, re, ra, me, ml, se, sl, le, ov, oa, lm);
  endfunction

  // Runs one job from an IDLE cycle; returns in the IDLE cycle that follows.
  task automatic run_job(input int id, input logic [7:0] sa, input logic [7:0] ea,
                         input logic [2:0] ll, input bit noise, input bit abort_w_start,
                         input int abort_cyc, input int rst_cyc);
    int n;
    n = int'(ea) - int'(sa) + 1;
    start = 1'b1; start_addr = sa; end_addr = ea; last_lanes = ll;
    abort = abort_w_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 3 * n + 12; c++) begin
      if (abort_cyc != 0 && c == abort_cyc + 1) begin
        check_eq($sformatf("j%0d_abort_c%0d", id, c), 32'(obs()), 32'd0);
        return;
      end
      check_eq($sformatf("j%0d_c%0d", id, c), 32'(obs()), 32'(exp_at(c, n, sa, ll)));
      if (c == 3 * n + 12) break;
      if (noise && c >= 3 && c <= 5) begin
        start = 1'b1; start_addr = 8'h00; end_addr = 8'hFF; last_lanes = 3'd1;
      end else begin
        start = 1'b0;
      end
      abort = (c == abort_cyc);
      if (c == rst_cyc) begin
        start = 1'b0; abort = 1'b0;
        #2 reset = 1'b0;
        #1 check_eq($sformatf("j%0d_async_rst", id), 32'(obs()), 32'd0);
        @(posedge clk); #1;
        check_eq($sformatf("j%0d_rst_hold", id), 32'(obs()), 32'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  // Rejected start: one err pulse, nothing else; abort in IDLE does nothing.
  task automatic run_reject(input int id, input logic [7:0] sa, input logic [7:0] ea,
                            input logic [2:0] ll);
    start = 1'b1; start_addr = sa; end_addr = ea; last_lanes = ll;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq($sformatf("r%0d_err", id), 32'(obs()),
             32'(pk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 8'h00, 4'h0)));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq($sformatf("r%0d_idle1", id), 32'(obs()), 32'd0);
    @(posedge clk); #1;
    check_eq($sformatf("r%0d_idle2", id), 32'(obs()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = 8'h00; end_addr = 8'h00; last_lanes = 3'd0;
    #1 check_eq("rst_outputs", 32'(obs()), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    check_eq("rst_held", 32'(obs()), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_idle", 32'(obs()), 32'd0);
    check_eq("latency_fn", 32'(job_latency(4, 2, 2, 1)), 32'd23);

    run_job(1, 8'h10, 8'h13, 3'd4, 1'b0, 1'b0, 0, 0);
    run_job(2, 8'h10, 8'h13, 3'd3, 1'b1, 1'b0, 0, 0);
    run_reject(3, 8'h20, 8'h1F, 3'd4);
    run_reject(4, 8'h10, 8'h13, 3'd0);
    run_reject(5, 8'h10, 8'h13, 3'd5);
    run_job(6, 8'hFE, 8'hFF, 3'd4, 1'b0, 1'b0, 0, 0);
    run_job(7, 8'h10, 8'h13, 3'd4, 1'b0, 1'b0, 9, 0);
    run_job(8, 8'h30, 8'h30, 3'd1, 1'b0, 1'b0, 0, 0);
    run_job(9, 8'h10, 8'h13, 3'd4, 1'b0, 1'b0, 0, 18);
    run_job(10, 8'h40, 8'h41, 3'd2, 1'b0, 1'b1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
